// File: rtl/check_state_if.sv
// Player-input stage bus: controller handshake, packed sequence, raw buttons and
// press/result reporting between the game controller and check_state.
interface check_state_if;
  logic        en_check;
  logic [31:0] seq_in_check;
  logic [3:0]  round_ctr;
  logic [3:0]  btn_in;
  logic [1:0]  press_colour;
  logic        press_valid;
  logic        pass_check;
  logic        fail_check;
  logic        complete_check;

  modport master (
    output en_check, seq_in_check, round_ctr, btn_in,
    input  press_colour, press_valid, pass_check, fail_check, complete_check
  );

  modport slave (
    input  en_check, seq_in_check, round_ctr, btn_in,
    output press_colour, press_valid, pass_check, fail_check, complete_check
  );
endinterface

// File: rtl/check_state.sv
// Memory-game player-input checker: accepts round_ctr+1 presses, compares each to the
// packed colour sequence, reports pass/fail. Define CHECK_DEBOUNCE_EN to debounce buttons.
module check_state #(
  parameter int                   TIMEOUT_W       = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES  = 24'd5_000_000,
  parameter logic [15:0]          DEBOUNCE_CYCLES = 16'd20_000
) (
  input logic         clk,
  input logic         rst_n_check,
  check_state_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - 1'b1;

  state_t               state, state_n;
  logic [3:0]           pos, pos_n;
  logic [TIMEOUT_W-1:0] timer, timer_n;
  logic [1:0]           colour_q, colour_n;
  logic                 pv_q, pv_n;
  logic                 pass_q, pass_n;
  logic                 fail_q, fail_n;
  logic                 done_q, done_n;

  logic [3:0] btn_m, btn_s, btn_use;
  logic [1:0] enc;
  logic       one_hot;
  logic [1:0] exp_col;

  always_ff @(posedge clk or negedge rst_n_check) begin
    if (!rst_n_check) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= bus.btn_in;
      btn_s <= btn_m;
    end
  end

`ifdef CHECK_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [3:0]  btn_db;
  logic [15:0] db_cnt [4];

  // A bit flips only after btn_s has disagreed with it for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk or negedge rst_n_check) begin
    if (!rst_n_check) begin
      btn_db <= '0;
      for (int unsigned k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (btn_s[k] != btn_db[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            btn_db[k] <= ~btn_db[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 16'd1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign btn_use = btn_db;
`else
  assign btn_use = btn_s;
`endif

  always_comb begin
    one_hot = 1'b1;
    enc     = 2'd0;
    case (btn_use)
      4'b0001: enc = 2'd0;
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  assign exp_col = bus.seq_in_check[{pos, 1'b0} +: 2];

  always_ff @(posedge clk or negedge rst_n_check) begin
    if (!rst_n_check) begin
      state    <= IDLE;
      pos      <= '0;
      timer    <= '0;
      colour_q <= '0;
      pv_q     <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      timer    <= timer_n;
      colour_q <= colour_n;
      pv_q     <= pv_n;
      pass_q   <= pass_n;
      fail_q   <= fail_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    timer_n  = timer;
    colour_n = colour_q;
    pv_n     = 1'b0;
    pass_n   = pass_q;
    fail_n   = fail_q;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.en_check) begin
          pos_n   = '0;
          timer_n = '0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          state_n = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        timer_n = timer + 1'b1;
        // A valid press takes priority over a timeout landing on the same cycle.
        if (one_hot) begin
          colour_n = enc;
          pv_n     = 1'b1;
          timer_n  = '0;
          if (enc == exp_col) begin
            state_n = WAIT_RELEASE;
          end else begin
            fail_n  = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (timer == TMO_LAST) begin
          fail_n  = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_use == 4'b0000) begin
          if (pos == bus.round_ctr) begin
            pass_n  = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            pos_n   = pos + 4'd1;
            timer_n = '0;
            state_n = WAIT_PRESS;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.press_colour   = colour_q;
  assign bus.press_valid    = pv_q;
  assign bus.pass_check     = pass_q;
  assign bus.fail_check     = fail_q;
  assign bus.complete_check = done_q;

endmodule

// File: tb/tb_check_state.sv
// Scoreboard bench for check_state: stimulus pushes expected events with the cycle
// they must appear on; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_check_state;
`ifdef CHECK_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 3 + DB;
  localparam int HOLD = LAT + 3;
  localparam int TMO  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic end_req = 1'b0;
  int   cyc = 0;

  check_state_if bus ();

  check_state #(
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (24'd100),
    .DEBOUNCE_CYCLES(16'd8)
  ) dut (
    .clk        (clk),
    .rst_n_check(rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS, EV_DONE, EV_RST, EV_LEVEL} kind_t;
  typedef struct {
    kind_t      kind;
    logic [1:0] col;
    logic       pass;
    logic       fail;
    int         at;
  } ev_t;

  ev_t q[$];
  int  passed = 0;
  int  total  = 0;

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      if (q.size() != 0 && q[0].kind == EV_RST) begin
        e = q.pop_front();
        total++;
        if ({bus.press_colour, bus.press_valid, bus.pass_check, bus.fail_check,
             bus.complete_check} == 6'b0)
          passed++;
        else
          $display("FAIL reset_outputs: got colour=%0d pv=%0b pass=%0b fail=%0b done=%0b, required all 0",
                   bus.press_colour, bus.press_valid, bus.pass_check, bus.fail_check,
                   bus.complete_check);
      end
    end else begin
      if (bus.press_valid) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL press: got unexpected press colour %0d at cycle %0d, required none",
                   bus.press_colour, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind == EV_PRESS && e.col == bus.press_colour && e.at == cyc)
            passed++;
          else
            $display("FAIL press: got colour %0d at cycle %0d, required event kind %0d colour %0d at cycle %0d",
                     bus.press_colour, cyc, e.kind, e.col, e.at);
        end
      end
      if (bus.complete_check) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL done: got unexpected done pass=%0b fail=%0b at cycle %0d, required none",
                   bus.pass_check, bus.fail_check, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind == EV_DONE && e.pass == bus.pass_check && e.fail == bus.fail_check &&
              e.at == cyc)
            passed++;
          else
            $display("FAIL done: got pass=%0b fail=%0b at cycle %0d, required kind %0d pass=%0b fail=%0b at cycle %0d",
                     bus.pass_check, bus.fail_check, cyc, e.kind, e.pass, e.fail, e.at);
        end
      end
      if (!bus.press_valid && !bus.complete_check && q.size() != 0 && q[0].kind == EV_LEVEL) begin
        e = q.pop_front();
        total++;
        if (e.pass == bus.pass_check && e.fail == bus.fail_check)
          passed++;
        else
          $display("FAIL result_level: got pass=%0b fail=%0b, required pass=%0b fail=%0b",
                   bus.pass_check, bus.fail_check, e.pass, e.fail);
      end
      if (end_req) begin
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL pending: got %0d expected events never seen, required 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input kind_t k, input logic [1:0] c, input logic p, input logic f,
                      input int at);
    ev_t e;
    e.kind = k;
    e.col  = c;
    e.pass = p;
    e.fail = f;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic start(input logic [31:0] s, input logic [3:0] rc, output int e0);
    bus.seq_in_check = s;
    bus.round_ctr    = rc;
    bus.en_check     = 1'b1;
    e0 = cyc;
    tick(1);
    bus.en_check = 1'b0;
  endtask

  // mode 0: ignored, 1: accepted, 2: accepted and last (pass on release), 3: mismatch
  task automatic press(input logic [3:0] b, input logic [1:0] c, input int mode);
    int t;
    t = cyc;
    if (mode != 0) push(EV_PRESS, c, 1'b0, 1'b0, t + LAT);
    if (mode == 3) push(EV_DONE, 2'd0, 1'b0, 1'b1, t + LAT);
    bus.btn_in = b;
    tick(HOLD);
    t = cyc;
    if (mode == 2) push(EV_DONE, 2'd0, 1'b1, 1'b0, t + LAT);
    bus.btn_in = 4'b0000;
    tick(HOLD);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int e0;
    int t;
    bus.en_check     = 1'b0;
    bus.seq_in_check = '0;
    bus.round_ctr    = '0;
    bus.btn_in       = '0;
    push(EV_RST, 2'd0, 1'b0, 1'b0, -1);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // full round: colours 0,1,2,3
    start(32'h0000_00E4, 4'd3, e0);
    push(EV_LEVEL, 2'd0, 1'b0, 1'b0, -1);
    press(4'b0001, 2'd0, 1);
    press(4'b0010, 2'd1, 1);
    press(4'b0100, 2'd2, 1);
    press(4'b1000, 2'd3, 2);
    drain();
    push(EV_LEVEL, 2'd0, 1'b1, 1'b0, -1);
    tick(3);

    // wrong second press; new start must clear the held pass
    start(32'h0000_00E4, 4'd1, e0);
    push(EV_LEVEL, 2'd0, 1'b0, 1'b0, -1);
    press(4'b0001, 2'd0, 1);
    press(4'b0100, 2'd2, 3);
    drain();
    push(EV_LEVEL, 2'd0, 1'b0, 1'b1, -1);
    tick(3);

    // inactivity timeout exactly TMO cycles after entering WAIT_PRESS
    start(32'h0000_00E4, 4'd0, e0);
    push(EV_DONE, 2'd0, 1'b0, 1'b1, e0 + TMO + 1);
    drain();
    tick(2);

    // press landing on the last timer cycle is accepted
    start(32'h0000_00E4, 4'd0, e0);
    while (cyc < e0 + TMO - 2 - DB) tick(1);
    press(4'b0001, 2'd0, 2);
    drain();
    tick(2);

    // multi-press ignored, then single press accepted
    start(32'h0000_00E4, 4'd0, e0);
    press(4'b0011, 2'd0, 0);
    press(4'b0001, 2'd0, 2);
    drain();
    tick(2);

`ifdef CHECK_DEBOUNCE_EN
    start(32'h0000_00E4, 4'd0, e0);
    repeat (5) begin
      bus.btn_in = 4'b0001;
      tick(3);
      bus.btn_in = 4'b0000;
      tick(3);
    end
    tick(HOLD);
    t = cyc;
    push(EV_PRESS, 2'd0, 1'b0, 1'b0, t + LAT);
    bus.btn_in = 4'b0001;
    tick(10);
    push(EV_DONE, 2'd0, 1'b1, 1'b0, cyc + LAT);
    bus.btn_in = 4'b0000;
    tick(HOLD);
    drain();
    tick(2);
`endif

    // reset mid-round at pos=2, then a fresh round must start at pos 0
    start(32'h0000_00E4, 4'd3, e0);
    press(4'b0001, 2'd0, 1);
    press(4'b0010, 2'd1, 1);
    drain();
    @(posedge clk);
    #1;
    push(EV_RST, 2'd0, 1'b0, 1'b0, -1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    start(32'h0000_00E4, 4'd0, e0);
    press(4'b0001, 2'd0, 2);
    drain();
    tick(2);

    end_req = 1'b1;
    tick(5);
    $display("FAIL summary: monitor did not finish");
    $fatal(1);
  end

endmodule
